// File: rtl/vball_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vball_pkg
//  Brief    : Shared types and constants for the sprite attribute RAM.
//  Revision : 1.0  initial release
// ============================================================================
package vball_pkg;

    // Controller phases: power-on clear, steady state, back->front transfer
    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        COPY = 2'd2
    } vball_state_e;

    localparam int SPR_RAM_DEPTH = 256;
    localparam int SPR_BYTES     = 4;
    localparam int SPR_COUNT     = 64;

endpackage : vball_pkg
`default_nettype wire

// File: rtl/vball_dpram.sv
`default_nettype none
// ============================================================================
//  Module   : vball_dpram
//  Brief    : Generic true dual-port RAM, 2**ADDR_W x DATA_W, registered
//             read-before-write outputs on both ports.
//  Revision : 1.0  initial release
// ============================================================================
module vball_dpram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    // port A
    input  logic              a_we_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [DATA_W-1:0] a_din_i,
    output logic [DATA_W-1:0] a_dout_o,
    // port B
    input  logic              b_we_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [DATA_W-1:0] b_din_i,
    output logic [DATA_W-1:0] b_dout_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] a_dout_q;
    logic [DATA_W-1:0] b_dout_q;

    // Array writes; contents are never reset, the owner clears them explicitly
    always_ff @(posedge clk_i) begin
        if (a_we_i) begin
            mem_q[a_addr_i] <= a_din_i;
        end
        if (b_we_i) begin
            mem_q[b_addr_i] <= b_din_i;
        end
    end

    // Registered reads sample the array before this edge's writes land
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_dout_q <= '0;
            b_dout_q <= '0;
        end else begin
            a_dout_q <= mem_q[a_addr_i];
            b_dout_q <= mem_q[b_addr_i];
        end
    end

    assign a_dout_o = a_dout_q;
    assign b_dout_o = b_dout_q;

endmodule : vball_dpram
`default_nettype wire

// File: rtl/vball_sprite_ram.sv
`default_nettype none
// ============================================================================
//  Module   : vball_sprite_ram
//  Brief    : Double-buffered 64 x 4-byte sprite attribute RAM. CPU owns the
//             back buffer, the renderer reads the front buffer, and a copy
//             engine moves back -> front on every vblank rising edge.
//  Revision : 1.0  initial release
// ============================================================================
module vball_sprite_ram
    import vball_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    input  logic              cpu_we,
    output logic [DATA_W-1:0] cpu_dout,
    input  logic              vblank,
    input  logic [ADDR_W-1:0] sma,
    output logic [DATA_W-1:0] smd,
    output logic              busy,
    output logic              copy_done
);

    localparam logic [ADDR_W-1:0] CTR_LAST = {ADDR_W{1'b1}};

    vball_state_e      state_q;
    logic [ADDR_W-1:0] ctr_q;
    logic              vblank_q;
    logic              pend_q;
    logic              drain_q;     // all reads issued, last front write pending
    logic              wr_vld_q;    // write stage holds a valid copy beat
    logic [ADDR_W-1:0] wr_addr_q;
    logic              byp_q;       // CPU wrote the address being read
    logic [DATA_W-1:0] byp_data_q;
    logic              busy_q;
    logic              copy_done_q;

    logic              rise;
    logic              back_a_we;
    logic              back_b_we;
    logic [DATA_W-1:0] back_rd;
    logic              front_a_we;
    logic [ADDR_W-1:0] front_a_addr;
    logic [DATA_W-1:0] front_a_din;
    logic [DATA_W-1:0] front_rd_unused;

    // Register vblank so its rising edge can be detected
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            vblank_q <= 1'b0;
        end else begin
            vblank_q <= vblank;
        end
    end

    assign rise = vblank & ~vblank_q;

    // Controller: clear sequencing, copy pipeline and registered status outputs
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= INIT;
            ctr_q       <= '0;
            pend_q      <= 1'b0;
            drain_q     <= 1'b0;
            wr_vld_q    <= 1'b0;
            wr_addr_q   <= '0;
            byp_q       <= 1'b0;
            byp_data_q  <= '0;
            busy_q      <= 1'b1;
            copy_done_q <= 1'b0;
        end else begin
            copy_done_q <= 1'b0;
            case (state_q)
                INIT: begin
                    // A vblank edge seen while clearing is remembered, not lost
                    if (rise) begin
                        pend_q <= 1'b1;
                    end
                    if (ctr_q == CTR_LAST) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        ctr_q   <= '0;
                    end else begin
                        ctr_q <= ctr_q + 1'b1;
                    end
                end
                IDLE: begin
                    if (rise || pend_q) begin
                        state_q <= COPY;
                        busy_q  <= 1'b1;
                        pend_q  <= 1'b0;
                        ctr_q   <= '0;
                        drain_q <= 1'b0;
                    end
                end
                COPY: begin
                    // Read stage issues back[ctr]; write stage lands it next cycle
                    wr_vld_q   <= ~drain_q;
                    wr_addr_q  <= ctr_q;
                    byp_q      <= cpu_we && (cpu_addr == ctr_q);
                    byp_data_q <= cpu_din;
                    if (!drain_q) begin
                        if (ctr_q == CTR_LAST) begin
                            drain_q <= 1'b1;
                        end else begin
                            ctr_q <= ctr_q + 1'b1;
                        end
                    end else begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        copy_done_q <= 1'b1;
                        wr_vld_q    <= 1'b0;
                        drain_q     <= 1'b0;
                        ctr_q       <= '0;
                    end
                end
                default: begin
                    state_q <= INIT;
                    busy_q  <= 1'b1;
                    ctr_q   <= '0;
                end
            endcase
        end
    end

    // Back buffer: CPU on port A (locked out while clearing), clear/copy on B
    assign back_a_we = cpu_we && (state_q != INIT);
    assign back_b_we = (state_q == INIT);

    // Front buffer: clear/copy writes on port A, renderer reads on port B
    assign front_a_we   = (state_q == INIT) || ((state_q == COPY) && wr_vld_q);
    assign front_a_addr = (state_q == INIT) ? ctr_q : wr_addr_q;
    assign front_a_din  = (state_q == INIT) ? '0 :
                          (byp_q ? byp_data_q : back_rd);

    vball_dpram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_back (
        .clk_i    (clk_sys),
        .rst_ni   (reset_n),
        .a_we_i   (back_a_we),
        .a_addr_i (cpu_addr),
        .a_din_i  (cpu_din),
        .a_dout_o (cpu_dout),
        .b_we_i   (back_b_we),
        .b_addr_i (ctr_q),
        .b_din_i  ('0),
        .b_dout_o (back_rd)
    );

    vball_dpram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_front (
        .clk_i    (clk_sys),
        .rst_ni   (reset_n),
        .a_we_i   (front_a_we),
        .a_addr_i (front_a_addr),
        .a_din_i  (front_a_din),
        .a_dout_o (front_rd_unused),
        .b_we_i   (1'b0),
        .b_addr_i (sma),
        .b_din_i  ('0),
        .b_dout_o (smd)
    );

    assign busy      = busy_q;
    assign copy_done = copy_done_q;

endmodule : vball_sprite_ram
`default_nettype wire

// File: tb/tb_vball_sprite_ram.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vball_sprite_ram
//  Brief    : Self-checking bench for vball_sprite_ram with a cycle-level
//             reference model and directed scenarios.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vball_sprite_ram;

    logic       clk_sys  = 1'b0;
    logic       reset_n  = 1'b1;
    logic [7:0] cpu_addr = 8'h00;
    logic [7:0] cpu_din  = 8'h00;
    logic       cpu_we   = 1'b0;
    logic       vblank   = 1'b0;
    logic [7:0] sma      = 8'h00;
    logic [7:0] cpu_dout;
    logic [7:0] smd;
    logic       busy;
    logic       copy_done;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    vball_sprite_ram #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .cpu_addr  (cpu_addr),
        .cpu_din   (cpu_din),
        .cpu_we    (cpu_we),
        .cpu_dout  (cpu_dout),
        .vblank    (vblank),
        .sma       (sma),
        .smd       (smd),
        .busy      (busy),
        .copy_done (copy_done)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // mode 0 = clearing, 1 = idle, 2 = copying; m_cyc counts cycles in phase
    int         m_mode = 0;
    int         m_cyc  = 0;
    bit         m_pend = 0;
    bit         m_vbprev = 0;
    bit         m_live = 0;
    logic [7:0] m_front [256];
    logic [7:0] m_back  [256];
    logic [7:0] m_snap  [256];

    always @(posedge clk_sys) begin : model
        int         pre;
        bit         rise, ck_smd, ck_dout, x_done, x_busy;
        logic [7:0] x_smd, x_dout;
        pre     = m_mode;
        ck_smd  = 0;
        ck_dout = 0;
        x_done  = 0;
        x_smd   = 8'h00;
        x_dout  = 8'h00;
        if (!reset_n) begin
            m_live   = 1;
            m_mode   = 0;
            m_cyc    = 0;
            m_pend   = 0;
            m_vbprev = 0;
            ck_smd   = 1;
            ck_dout  = 1;
        end else if (m_live) begin
            x_smd   = m_front[sma];
            x_dout  = m_back[cpu_addr];
            ck_smd  = (pre == 1);
            ck_dout = (pre != 0);
            rise     = vblank && !m_vbprev;
            m_vbprev = vblank;
            case (m_mode)
                0: begin
                    m_front[m_cyc] = 8'h00;
                    m_back[m_cyc]  = 8'h00;
                    if (rise) m_pend = 1;
                    if (m_cyc == 255) m_mode = 1;
                    else m_cyc++;
                end
                1: begin
                    if (cpu_we) m_back[cpu_addr] = cpu_din;
                    if (rise || m_pend) begin
                        m_mode = 2;
                        m_cyc  = 0;
                        m_pend = 0;
                    end
                end
                default: begin
                    // copied value for entry k is whatever back[k] holds on
                    // cycle k, with a same-cycle CPU write taking precedence
                    if (m_cyc < 256)
                        m_snap[m_cyc] = (cpu_we && cpu_addr == m_cyc) ? cpu_din : m_back[m_cyc];
                    if (cpu_we) m_back[cpu_addr] = cpu_din;
                    if (m_cyc == 256) begin
                        m_front = m_snap;
                        m_mode  = 1;
                        x_done  = 1;
                    end
                    m_cyc++;
                end
            endcase
        end
        x_busy = (m_mode != 1);
        #1;
        if (m_live) begin
            chk("busy", busy, x_busy);
            chk("copy_done", copy_done, x_done);
            if (ck_smd)  chk("smd", smd, x_smd);
            if (ck_dout) chk("cpu_dout", cpu_dout, x_dout);
            if (copy_done === 1'b1) done_cnt++;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_done(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk_sys);
            n++;
        end while (copy_done !== 1'b1 && n < limit);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            sma = n[7:0];
            n++;
            @(negedge clk_sys);
        end
    endtask

    initial begin : stim
        int n;
        int d0;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("reset_busy", busy, 1);
        chk("reset_smd", smd, 0);

        // 1: clear after reset, then sweep the whole front buffer
        reset_n = 1'b1;
        count_busy(n);
        chk("init_busy_cycles", n, 256);
        for (int i = 0; i < 256; i++) begin
            sma = i[7:0];
            @(negedge clk_sys);
        end
        chk("init_no_done", done_cnt, 0);

        // 2: CPU write lands in back only until the next vblank copy
        cpu_addr = 8'h10; cpu_din = 8'h5A; cpu_we = 1'b1;
        @(negedge clk_sys);
        cpu_we = 1'b0; sma = 8'h10;
        @(negedge clk_sys);
        chk("pre_copy_smd", smd, 8'h00);
        chk("pre_copy_dout", cpu_dout, 8'h5A);
        vblank = 1'b1;
        wait_done(600, n);
        chk("copy_latency", n, 258);
        vblank = 1'b0;
        @(negedge clk_sys);
        chk("post_copy_smd", smd, 8'h5A);

        // 3: bypass on the exact read cycle, late write to an already copied slot
        repeat (4) @(negedge clk_sys);
        vblank = 1'b1;
        @(negedge clk_sys);
        repeat (40) @(negedge clk_sys);
        cpu_we = 1'b1; cpu_addr = 8'd40; cpu_din = 8'hC3;
        @(negedge clk_sys);
        cpu_addr = 8'd35; cpu_din = 8'h77;
        @(negedge clk_sys);
        cpu_we = 1'b0;
        wait_done(600, n);
        chk("bypass_copy_done", copy_done, 1);
        vblank = 1'b0;
        sma = 8'd40;
        @(negedge clk_sys);
        chk("bypass_front", smd, 8'hC3);
        sma = 8'd35; cpu_addr = 8'd35;
        @(negedge clk_sys);
        chk("late_front_stale", smd, 8'h00);
        chk("late_back", cpu_dout, 8'h77);
        vblank = 1'b1;
        wait_done(600, n);
        vblank = 1'b0;
        @(negedge clk_sys);
        chk("late_front_next", smd, 8'h77);
        sma = 8'd40;
        @(negedge clk_sys);
        chk("bypass_front_kept", smd, 8'hC3);

        // 4: vblank during the clear is deferred until the clear finishes
        reset_n = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (100) @(negedge clk_sys);
        vblank = 1'b1;
        n = 100;
        while (copy_done !== 1'b1 && n < 2000) begin
            @(negedge clk_sys);
            n++;
        end
        chk("deferred_done_cycle", n, 514);
        vblank = 1'b0;
        repeat (3) @(negedge clk_sys);

        // 5: second rise during a copy is ignored
        d0 = done_cnt;
        vblank = 1'b1;
        @(negedge clk_sys);
        vblank = 1'b0;
        repeat (50) @(negedge clk_sys);
        vblank = 1'b1;
        @(negedge clk_sys);
        vblank = 1'b0;
        repeat (400) @(negedge clk_sys);
        chk("single_done", done_cnt - d0, 1);
        chk("idle_after_copy", busy, 0);

        // 6: reset in the middle of a copy restarts the clear
        cpu_addr = 8'h10; cpu_din = 8'hA5; cpu_we = 1'b1;
        @(negedge clk_sys);
        cpu_we = 1'b0;
        d0 = done_cnt;
        vblank = 1'b1;
        @(negedge clk_sys);
        vblank = 1'b0;
        repeat (120) @(negedge clk_sys);
        reset_n = 1'b0;
        @(negedge clk_sys);
        chk("abort_busy", busy, 1);
        chk("abort_done", copy_done, 0);
        reset_n = 1'b1;
        count_busy(n);
        chk("reinit_busy_cycles", n, 256);
        for (int i = 0; i < 256; i++) begin
            sma = i[7:0];
            @(negedge clk_sys);
        end
        sma = 8'h10; cpu_addr = 8'h10;
        @(negedge clk_sys);
        chk("reinit_smd", smd, 8'h00);
        chk("reinit_back", cpu_dout, 8'h00);
        chk("abort_no_done", done_cnt - d0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule : tb_vball_sprite_ram
`default_nettype wire
